axi_llc_data_way_pipe: RTL and testbench

AXI_LLC_DATA_WAY_PIPE -- requirements
Module: axi_llc_data_way_pipe

---
 rtl/axi_llc_data_way_pipe.sv | 166 ++++++++++++++++
 tb/tb_axi_llc_data_way_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_llc_data_way_pipe.sv
// rtl/axi_llc_data_way_pipe.sv - LLC data-way SRAM pipe with read-credit flow control and response FIFO
// Optional performance counters are built when AXI_LLC_DATA_WAY_PERF_EN is defined.
module axi_llc_data_way_pipe #(
  parameter int DataWidth = 128,
  parameter int AddrWidth = 10,
  parameter int UnitWidth = 2,
  parameter int Latency   = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   inp_valid_i,
  output logic                   inp_ready_o,
  input  logic                   inp_we_i,
  input  logic [AddrWidth-1:0]   inp_addr_i,
  input  logic [DataWidth-1:0]   inp_wdata_i,
  input  logic [DataWidth/8-1:0] inp_strb_i,
  input  logic [UnitWidth-1:0]   inp_unit_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DataWidth-1:0]   out_data_o,
  output logic [UnitWidth-1:0]   out_unit_o,
  output logic                   ram_req_o,
  output logic                   ram_we_o,
  output logic [AddrWidth-1:0]   ram_addr_o,
  output logic [DataWidth-1:0]   ram_wdata_o,
  output logic [DataWidth/8-1:0] ram_be_o,
  input  logic                   ram_gnt_i,
  input  logic [DataWidth-1:0]   ram_rdata_i,
  output logic [31:0]            perf_reads_o,
  output logic [31:0]            perf_writes_o,
  output logic [31:0]            perf_stalls_o
);

  localparam int PtrWidth = (Latency > 1) ? $clog2(Latency) : 1;
  localparam int CntWidth = $clog2(Latency + 1);
  localparam int SumWidth = CntWidth + 1;
  localparam logic [SumWidth-1:0] LatSum = SumWidth'(Latency);

  logic [Latency-1:0]   sr_valid_q, sr_valid_d;
  logic [UnitWidth-1:0] sr_unit_q [Latency];
  logic [UnitWidth-1:0] sr_unit_d [Latency];

  logic [DataWidth-1:0] fifo_data_q [Latency];
  logic [UnitWidth-1:0] fifo_unit_q [Latency];
  logic [PtrWidth-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntWidth-1:0]  count_q, count_d;

  logic                 ret_valid;
  logic [UnitWidth-1:0] ret_unit;
  logic                 fifo_empty;
  logic                 push, pop, out_hs;
  logic [SumWidth-1:0]  outstanding;
  logic                 credit_ok;
  logic                 fire, rd_fire;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Latency - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  // The last shift stage lines up with the cycle the macro drives read data.
  assign ret_valid  = sr_valid_q[Latency-1];
  assign ret_unit   = sr_unit_q[Latency-1];
  assign fifo_empty = (count_q == '0);

  assign out_valid_o = !rst_i && (fifo_empty ? ret_valid : 1'b1);
  assign out_data_o  = fifo_empty ? ram_rdata_i : fifo_data_q[rptr_q];
  assign out_unit_o  = fifo_empty ? ret_unit : fifo_unit_q[rptr_q];
  assign out_hs      = out_valid_o && out_ready_i;

  assign push = !rst_i && ret_valid && (!fifo_empty || !out_ready_i);
  assign pop  = !rst_i && !fifo_empty && out_ready_i;

  always_comb begin
    outstanding = SumWidth'(count_q);
    for (int i = 0; i < Latency; i++) begin
      outstanding = outstanding + SumWidth'(sr_valid_q[i]);
    end
  end

  // Every read in flight or queued owns a FIFO slot, so the buffer cannot overflow.
  assign credit_ok   = (outstanding < LatSum) || ((outstanding == LatSum) && out_hs);
  assign inp_ready_o = !rst_i && ram_gnt_i && (inp_we_i || credit_ok);
  assign fire        = inp_valid_i && inp_ready_o;
  assign rd_fire     = fire && !inp_we_i;

  assign ram_req_o   = fire;
  assign ram_we_o    = inp_we_i;
  assign ram_addr_o  = inp_addr_i;
  assign ram_wdata_o = inp_wdata_i;
  assign ram_be_o    = inp_strb_i;

  always_comb begin
    sr_valid_d    = '0;
    sr_valid_d[0] = rd_fire;
    sr_unit_d[0]  = inp_unit_i;
    for (int i = 1; i < Latency; i++) begin
      sr_valid_d[i] = sr_valid_q[i-1];
      sr_unit_d[i]  = sr_unit_q[i-1];
    end
  end

  always_comb begin
    wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = pop ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_valid_q <= '0;
      for (int i = 0; i < Latency; i++) begin
        sr_unit_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      sr_valid_q <= sr_valid_d;
      sr_unit_q  <= sr_unit_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wptr_q] <= ram_rdata_i;
      fifo_unit_q[wptr_q] <= ret_unit;
    end
  end

`ifdef AXI_LLC_DATA_WAY_PERF_EN
  logic [31:0] perf_reads_q, perf_writes_q, perf_stalls_q;
  logic        wr_fire, stall;

  assign wr_fire = fire && inp_we_i;
  assign stall   = inp_valid_i && !inp_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_reads_q  <= '0;
      perf_writes_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (rd_fire && (perf_reads_q != '1))  perf_reads_q  <= perf_reads_q + 32'd1;
      if (wr_fire && (perf_writes_q != '1)) perf_writes_q <= perf_writes_q + 32'd1;
      if (stall && (perf_stalls_q != '1))   perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_reads_o  = perf_reads_q;
  assign perf_writes_o = perf_writes_q;
  assign perf_stalls_o = perf_stalls_q;
`else
  assign perf_reads_o  = '0;
  assign perf_writes_o = '0;
  assign perf_stalls_o = '0;
`endif

endmodule

// File: tb/tb_axi_llc_data_way_pipe.sv
// tb/tb_axi_llc_data_way_pipe.sv - random and directed bench for axi_llc_data_way_pipe against a queue model
module tb_axi_llc_data_way_pipe;
  localparam int LAT = 2;
  localparam int DW  = 128;
  localparam int AW  = 10;
  localparam int UW  = 2;
  localparam int SW  = DW / 8;
`ifdef AXI_LLC_DATA_WAY_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, inp_valid_i, inp_ready_o, inp_we_i;
  logic [AW-1:0] inp_addr_i;
  logic [DW-1:0] inp_wdata_i;
  logic [SW-1:0] inp_strb_i;
  logic [UW-1:0] inp_unit_i;
  logic          out_valid_o, out_ready_i;
  logic [DW-1:0] out_data_o;
  logic [UW-1:0] out_unit_o;
  logic          ram_req_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o;
  logic [SW-1:0] ram_be_o;
  logic          ram_gnt_i;
  logic [DW-1:0] ram_rdata_i;
  logic [31:0]   perf_reads_o, perf_writes_o, perf_stalls_o;

  axi_llc_data_way_pipe #(
    .DataWidth(DW), .AddrWidth(AW), .UnitWidth(UW), .Latency(LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .inp_valid_i(inp_valid_i), .inp_ready_o(inp_ready_o), .inp_we_i(inp_we_i),
    .inp_addr_i(inp_addr_i), .inp_wdata_i(inp_wdata_i), .inp_strb_i(inp_strb_i),
    .inp_unit_i(inp_unit_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_unit_o(out_unit_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o),
    .ram_gnt_i(ram_gnt_i), .ram_rdata_i(ram_rdata_i),
    .perf_reads_o(perf_reads_o), .perf_writes_o(perf_writes_o), .perf_stalls_o(perf_stalls_o)
  );

  typedef struct { logic [DW-1:0] d; logic [UW-1:0] u; int c; } rsp_t;
  typedef struct { logic [DW-1:0] d; int c; } rd_t;

  rsp_t          rq[$];
  rd_t           sq[$];
  logic [DW-1:0] mem [1<<AW];
  int            cyc, n_cmp, n_err, acc_obs, rsp_obs, last_rsp_cyc, rd_cyc;
  logic [DW-1:0] last_data;
  logic [UW-1:0] last_unit;
  int unsigned   m_rd, m_wr, m_st;

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [UW-1:0] u,
                      input bit ordy, input bit gnt);
    bit            e_ov, e_pop, e_ir, e_fire;
    logic [DW-1:0] nd;
    rsp_t          re;
    rd_t           se;
    rst_i = r; inp_valid_i = v; inp_we_i = w; inp_addr_i = a; inp_wdata_i = d;
    inp_strb_i = s; inp_unit_i = u; out_ready_i = ordy; ram_gnt_i = gnt;
    @(negedge clk);
    e_ov   = !r && (rq.size() > 0) && (rq[0].c <= cyc);
    e_pop  = e_ov && ordy;
    e_ir   = !r && gnt && (w || (rq.size() < LAT) || ((rq.size() == LAT) && e_pop));
    e_fire = v && e_ir;
    check_val("inp_ready", DW'(inp_ready_o), DW'(e_ir));
    check_val("out_valid", DW'(out_valid_o), DW'(e_ov));
    if (e_ov) begin
      check_val("out_data", out_data_o, rq[0].d);
      check_val("out_unit", DW'(out_unit_o), DW'(rq[0].u));
    end
    check_val("ram_req", DW'(ram_req_o), DW'(e_fire));
    if (v) begin
      check_val("ram_cmd", DW'({ram_we_o, ram_addr_o, ram_be_o}), DW'({w, a, s}));
      check_val("ram_wdata", ram_wdata_o, d);
    end
    check_val("perf_reads", DW'(perf_reads_o), PerfEn ? DW'(m_rd) : '0);
    check_val("perf_writes", DW'(perf_writes_o), PerfEn ? DW'(m_wr) : '0);
    check_val("perf_stalls", DW'(perf_stalls_o), PerfEn ? DW'(m_st) : '0);
    if (v && inp_ready_o) acc_obs++;
    if (out_valid_o && out_ready_i) begin
      rsp_obs++;
      last_data = out_data_o;
      last_unit = out_unit_o;
      last_rsp_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (r) begin
      rq.delete();
      m_rd = 0; m_wr = 0; m_st = 0;
    end else begin
      if (v && !e_ir) m_st++;
      if (e_pop) void'(rq.pop_front());
      if (e_fire && w) begin
        nd = mem[a];
        for (int b = 0; b < SW; b++) if (s[b]) nd[8*b +: 8] = d[8*b +: 8];
        mem[a] = nd;
        m_wr++;
      end else if (e_fire) begin
        re.d = mem[a]; re.u = u; re.c = cyc + LAT;
        rq.push_back(re);
        se.d = mem[a]; se.c = cyc + LAT;
        sq.push_back(se);
        m_rd++;
      end
    end
    cyc++;
    // Macro model keeps returning pre-reset reads; anything else on the bus is noise.
    if ((sq.size() > 0) && (sq[0].c == cyc)) begin
      ram_rdata_i = sq[0].d;
      void'(sq.pop_front());
    end else begin
      ram_rdata_i = rnd_data();
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    repeat (n) step(1'b0, 1'b0, 1'b0, '0, rnd_data(), '0, '0, ordy, 1'b1);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [UW-1:0] u, input bit ordy);
    step(1'b0, 1'b1, 1'b0, a, rnd_data(), '0, u, ordy, 1'b1);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [UW-1:0] u);
    step(1'b0, 1'b1, 1'b1, a, d, '1, u, 1'b1, 1'b1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; acc_obs = 0; rsp_obs = 0; last_rsp_cyc = 0;
    m_rd = 0; m_wr = 0; m_st = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = rnd_data();
    rst_i = 1'b1; inp_valid_i = 1'b0; inp_we_i = 1'b0; inp_addr_i = '0;
    inp_wdata_i = '0; inp_strb_i = '0; inp_unit_i = '0; out_ready_i = 1'b0;
    ram_gnt_i = 1'b1; ram_rdata_i = rnd_data();
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 1'b1, 1'b0, '0, rnd_data(), '0, '0, 1'b1, 1'b1);

    // Write then read the same word; first request lands right after reset release.
    acc_obs = 0; rsp_obs = 0;
    wr(10'h005, {16{8'hA5}}, 2'd1);
    rd_cyc = cyc;
    rd(10'h005, 2'd2, 1'b1);
    idle(LAT + 1, 1'b1);
    check_val("wr_rd_accepts", DW'(acc_obs), DW'(2));
    check_val("wr_rd_data", last_data, {16{8'hA5}});
    check_val("wr_rd_unit", DW'(last_unit), DW'(2));
    check_val("wr_rd_latency", DW'(last_rsp_cyc - rd_cyc), DW'(LAT));

    // Back-to-back reads with the consumer always ready.
    acc_obs = 0; rsp_obs = 0;
    for (int i = 0; i < 6; i++) rd(AW'(i), UW'(i), 1'b1);
    check_val("b2b_accepts", DW'(acc_obs), DW'(6));
    idle(LAT + 1, 1'b1);
    check_val("b2b_responses", DW'(rsp_obs), DW'(6));

    // Blocked consumer: only LAT reads may be taken.
    acc_obs = 0; rsp_obs = 0;
    for (int i = 0; i < 4; i++) rd(AW'(20 + i), UW'(i), 1'b0);
    check_val("bp_accepts", DW'(acc_obs), DW'(LAT));
    idle(LAT + 1, 1'b1);
    check_val("bp_drained", DW'(rsp_obs), DW'(LAT));
    acc_obs = 0;
    rd(10'h030, 2'd3, 1'b1);
    check_val("bp_resume", DW'(acc_obs), DW'(1));
    idle(LAT + 1, 1'b1);

    // No grant for five cycles.
    acc_obs = 0;
    repeat (5) step(1'b0, 1'b1, 1'b0, 10'h040, rnd_data(), '0, 2'd1, 1'b1, 1'b0);
    check_val("nogrant_accepts", DW'(acc_obs), DW'(0));

    // Reset right after two reads fire: nothing may come back.
    rd(10'h050, 2'd1, 1'b1);
    rd(10'h051, 2'd2, 1'b1);
    rsp_obs = 0;
    step(1'b1, 1'b0, 1'b0, '0, rnd_data(), '0, '0, 1'b1, 1'b1);
    idle(LAT + 3, 1'b1);
    check_val("rst_responses", DW'(rsp_obs), DW'(0));

    // Interleaved write/read/write/read.
    rsp_obs = 0;
    wr(10'h060, rnd_data(), 2'd0);
    rd(10'h060, 2'd1, 1'b1);
    wr(10'h061, rnd_data(), 2'd0);
    rd(10'h061, 2'd3, 1'b1);
    idle(LAT + 2, 1'b1);
    check_val("mix_responses", DW'(rsp_obs), DW'(2));
    check_val("mix_last_unit", DW'(last_unit), DW'(3));

    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 2000; i++) begin
        step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
             AW'($urandom_range(0, 15)), rnd_data(), SW'($urandom()), UW'($urandom()),
             (ph == 0) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 9) < 9),
             $urandom_range(0, 9) < 8);
      end
    end
    idle(LAT + 2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
